// File: rtl/wb_bram_prefetch.sv
// Wishbone BRAM slave with a fixed-latency read pipeline and a sequential prefetch buffer.
// Define WB_PF_STATS_EN to build the saturating prefetch hit/miss counters.
module wb_bram_prefetch #(
  parameter int ADDR_W   = 12,
  parameter int BRAM_LAT = 10,
  parameter int PF_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] pf_hit_cnt,
  output logic [15:0] pf_miss_cnt
);

  localparam int                PF_W       = $clog2(PF_DEPTH);
  localparam int                MEM_WORDS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PF_DEPTH_A = ADDR_W'(PF_DEPTH);
  localparam logic [PF_W:0]     PF_CNT     = (PF_W+1)'(PF_DEPTH);
  localparam logic [PF_W-1:0]   LAST_IDX   = PF_W'(PF_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, ACK} state_t;

  state_t            r_state;
  logic              r_ack;
  logic [31:0]       r_dat;
  logic              r_valid;
  logic [ADDR_W-1:0] r_tag;
  logic [PF_W:0]     r_issue_cnt;
  logic              r_abandon;

  logic [31:0]       r_mem      [MEM_WORDS];
  logic [31:0]       r_buf      [PF_DEPTH];
  logic [31:0]       r_pipe_dat [BRAM_LAT];
  logic [PF_W-1:0]   r_pipe_idx [BRAM_LAT];
  logic [BRAM_LAT-1:0] r_pipe_vld;

  logic              w_req;
  logic              w_idle_req;
  logic [ADDR_W-1:0] w_adr;
  logic [ADDR_W-1:0] w_diff;
  logic              w_in_buf;
  logic [PF_W-1:0]   w_buf_idx;
  logic              w_wr;
  logic              w_rd_hit;
  logic              w_rd_miss;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_adr;
  logic              w_cap;
  logic [PF_W-1:0]   w_cap_idx;
  logic [31:0]       w_cap_dat;
  logic [31:0]       w_bmask;
  logic [31:0]       w_buf_merged;
  logic              w_unused_adr;

  assign w_req       = sel_i & wbs_cyc_i & wbs_stb_i;
  assign w_idle_req  = (r_state == IDLE) & w_req;
  assign w_adr       = wbs_adr_i[ADDR_W+1:2];
  // Modular distance from the buffer base makes wrap-around windows hit naturally.
  assign w_diff      = w_adr - r_tag;
  assign w_in_buf    = r_valid & (w_diff < PF_DEPTH_A);
  assign w_buf_idx   = w_diff[PF_W-1:0];
  assign w_wr        = w_idle_req & wbs_we_i;
  assign w_rd_hit    = w_idle_req & ~wbs_we_i & w_in_buf;
  assign w_rd_miss   = w_idle_req & ~wbs_we_i & ~w_in_buf;
  assign w_issue     = (r_state == FILL) & (r_issue_cnt < PF_CNT);
  assign w_issue_adr = r_tag + ADDR_W'(r_issue_cnt);
  assign w_cap       = r_pipe_vld[BRAM_LAT-1];
  assign w_cap_idx   = r_pipe_idx[BRAM_LAT-1];
  assign w_cap_dat   = r_pipe_dat[BRAM_LAT-1];
  assign w_unused_adr = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_bmask
    assign w_bmask[8*gi +: 8] = {8{wbs_sel_i[gi]}};
  end

  assign w_buf_merged = (r_buf[w_buf_idx] & ~w_bmask) | (wbs_dat_i & w_bmask);

  // Memory array and read data path carry no reset so they map onto block RAM.
  always_ff @(posedge wb_clk_i) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) r_mem[w_adr][8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
    if (w_issue) begin
      r_pipe_dat[0] <= r_mem[w_issue_adr];
      r_pipe_idx[0] <= r_issue_cnt[PF_W-1:0];
    end
    for (int i = 1; i < BRAM_LAT; i++) begin
      r_pipe_dat[i] <= r_pipe_dat[i-1];
      r_pipe_idx[i] <= r_pipe_idx[i-1];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_cap) r_buf[w_cap_idx] <= w_cap_dat;
    if (w_wr && w_in_buf) r_buf[w_buf_idx] <= w_buf_merged;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      for (int i = 1; i < BRAM_LAT; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= IDLE;
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_valid     <= 1'b0;
      r_tag       <= '0;
      r_issue_cnt <= '0;
      r_abandon   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_wr) begin
            r_ack   <= 1'b1;
            r_state <= ACK;
          end else if (w_rd_hit) begin
            r_ack   <= 1'b1;
            r_dat   <= r_buf[w_buf_idx];
            r_state <= ACK;
          end else if (w_rd_miss) begin
            r_valid     <= 1'b0;
            r_tag       <= w_adr;
            r_issue_cnt <= '0;
            r_abandon   <= 1'b0;
            r_state     <= FILL;
          end
        end
        FILL: begin
          if (w_issue) r_issue_cnt <= r_issue_cnt + (PF_W+1)'(1);
          if (!wbs_cyc_i) r_abandon <= 1'b1;
          if (w_cap) begin
            if (w_cap_idx == '0) begin
              r_dat <= w_cap_dat;
              r_ack <= ~r_abandon & wbs_cyc_i;
            end
            if (w_cap_idx == LAST_IDX) begin
              r_valid <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

`ifdef WB_PF_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_rd_hit && (r_hit_cnt != 16'hFFFF)) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (w_rd_miss && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign pf_hit_cnt  = r_hit_cnt;
  assign pf_miss_cnt = r_miss_cnt;
`else
  assign pf_hit_cnt  = 16'd0;
  assign pf_miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_wb_bram_prefetch.sv
// Directed bench for wb_bram_prefetch: latency, data, coherence, wrap, reset and abandon cases.
module tb_wb_bram_prefetch;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  bsel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int total;
  int passed;
  int fails;

  wb_bram_prefetch #(.ADDR_W(12), .BRAM_LAT(10), .PF_DEPTH(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .sel_i      (sel),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (bsel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .pf_hit_cnt (hit_cnt),
    .pf_miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req_start(input logic [11:0] wa, input logic w, input logic [3:0] s, input logic [31:0] d);
    adr  = {18'd0, wa, 2'b00};
    we   = w;
    bsel = s;
    wdat = d;
    sel  = 1'b1;
    cyc  = 1'b1;
    stb  = 1'b1;
  endtask

  task automatic req_drop();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  // Counts edges from the request until ack is seen; an expired budget fails the ack check.
  task automatic wait_ack(input string name, input int exp_lat, input logic chk_dat, input logic [31:0] exp_dat);
    int lat;
    logic got;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      tick(1);
      lat++;
      if (ack) got = 1'b1;
    end
    $display("%s adr=%03h we=%0b lat=%0d dat=%08h", name, adr[13:2], we, lat, rdat);
    check({name, "_ack"}, 32'(got), 32'd1);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    if (chk_dat) check({name, "_dat"}, rdat, exp_dat);
  endtask

  task automatic wb_write(input string name, input logic [11:0] wa, input logic [31:0] d, input logic [3:0] s);
    req_start(wa, 1'b1, s, d);
    wait_ack(name, 1, 1'b0, 32'd0);
    req_drop();
    tick(2);
  endtask

  task automatic wb_read(input string name, input logic [11:0] wa, input logic [31:0] exp_dat, input int exp_lat);
    req_start(wa, 1'b0, 4'hF, 32'd0);
    wait_ack(name, exp_lat, 1'b1, exp_dat);
    req_drop();
    tick(5);
  endtask

  initial begin
    int acks;
    total  = 0;
    passed = 0;
    fails  = 0;
    rst_n  = 1'b0;
    sel    = 1'b0;
    cyc    = 1'b0;
    stb    = 1'b0;
    we     = 1'b0;
    bsel   = 4'h0;
    adr    = '0;
    wdat   = '0;
    tick(3);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_hit", 32'(hit_cnt), 32'd0);
    check("rst_miss", 32'(miss_cnt), 32'd0);
    rst_n = 1'b1;
    tick(2);

    wb_write("pre10", 12'h010, 32'h11111111, 4'hF);
    wb_write("pre11", 12'h011, 32'h22222222, 4'hF);
    wb_write("pre12", 12'h012, 32'h33333333, 4'hF);
    wb_write("pre13", 12'h013, 32'h44444444, 4'hF);
    wb_write("pre20", 12'h020, 32'hA0A0A0A0, 4'hF);
    wb_write("pre21", 12'h021, 32'hA1A1A1A1, 4'hF);
    wb_write("pre40", 12'h040, 32'h40404040, 4'hF);
    wb_write("pre41", 12'h041, 32'h41414141, 4'hF);
    wb_write("preFFE", 12'hFFE, 32'hFEFEFEFE, 4'hF);
    wb_write("preFFF", 12'hFFF, 32'hFFFFFFF0, 4'hF);
    wb_write("pre000", 12'h000, 32'h00000A00, 4'hF);
    wb_write("pre001", 12'h001, 32'h00000A01, 4'hF);

    // Sequential reads: one miss then three hits.
    wb_read("rd10", 12'h010, 32'h11111111, 12);
    wb_read("rd11", 12'h011, 32'h22222222, 1);
    wb_read("rd12", 12'h012, 32'h33333333, 1);
    wb_read("rd13", 12'h013, 32'h44444444, 1);
`ifdef WB_PF_STATS_EN
    check("stat_hit", 32'(hit_cnt), 32'd3);
    check("stat_miss", 32'(miss_cnt), 32'd1);
`else
    check("stat_hit_off", 32'(hit_cnt), 32'd0);
    check("stat_miss_off", 32'(miss_cnt), 32'd0);
`endif

    // Partial write into a buffered word, then cached and uncached readback.
    wb_write("wr12", 12'h012, 32'hAABBCCDD, 4'b0011);
    wb_read("rd12_hit", 12'h012, 32'h3333CCDD, 1);
    wb_read("rd10_after", 12'h010, 32'h11111111, 1);
    wb_read("rd_evict", 12'h040, 32'h40404040, 12);
    wb_read("rd12_miss", 12'h012, 32'h3333CCDD, 12);

    // Prefetch window wrapping past the top of memory.
    wb_read("rdFFE", 12'hFFE, 32'hFEFEFEFE, 12);
    wb_read("rd000", 12'h000, 32'h00000A00, 1);
    wb_read("rd001", 12'h001, 32'h00000A01, 1);

    // Reset during a fill discards it.
    req_start(12'h010, 1'b0, 4'hF, 32'd0);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_dat", rdat, 32'd0);
    req_drop();
    tick(3);
    check("mid_rst_ack2", 32'(ack), 32'd0);
    rst_n = 1'b1;
    tick(2);
    wb_read("rd10_postrst", 12'h010, 32'h11111111, 12);

    // Back-to-back request held off while the fill completes.
    req_start(12'h020, 1'b0, 4'hF, 32'd0);
    wait_ack("rd20", 12, 1'b1, 32'hA0A0A0A0);
    req_start(12'h021, 1'b0, 4'hF, 32'd0);
    wait_ack("rd21_wait", 4, 1'b1, 32'hA1A1A1A1);
    req_drop();
    tick(5);

    // Write with no byte lanes is acked but changes nothing.
    wb_write("wr21_nosel", 12'h021, 32'hDEADBEEF, 4'b0000);
    wb_read("rd21_nosel", 12'h021, 32'hA1A1A1A1, 1);

    // Abandoned miss: no ack, but the buffer still fills.
    req_start(12'h040, 1'b0, 4'hF, 32'd0);
    tick(3);
    req_drop();
    acks = 0;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (ack) acks++;
    end
    $display("abandon adr=040 acks=%0d", acks);
    check("abandon_acks", 32'(acks), 32'd0);
    wb_read("rd41_after_abandon", 12'h041, 32'h41414141, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
